fifo_buffer_ext: RTL and testbench

Next-generation synchronous FIFO, parametrised in word length, depth, threshold levels and read mode. It adds the following on top of the basic full/empty/error buffer:
- occupancy count
- programmable almost-full and almost-empty flags
- first-word-fall-through option
- flush
- separate overflow/underflow pulses with a sticky, clearable error
It sits between producer and consumer blocks in the same clock domain as a drop-in elastic buffer.

---
 rtl/fifo_buffer_ext.sv | 110 +++++++++++
 tb/tb_fifo_buffer_ext.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_buffer_ext.sv
// rtl/fifo_buffer_ext.sv - synchronous elastic FIFO with occupancy, threshold flags, FWFT, flush and sticky error
module fifo_buffer_ext #(
    parameter int WL     = 8,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           wReq,
    input  logic                           rReq,
    input  logic [WL-1:0]                  din,
    input  logic                           Flush,
    input  logic                           ErrClr,
    output logic [WL-1:0]                  dout,
    output logic                           Full,
    output logic                           Empty,
    output logic                           AlmostFull,
    output logic                           AlmostEmpty,
    output logic [$clog2(DEPTH+1)-1:0]     Count,
    output logic                           Overflow,
    output logic                           Underflow,
    output logic                           Error
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] L_AF    = CW'(AF_LVL);
    localparam logic [CW-1:0] L_AE    = CW'(AE_LVL);
    localparam logic [AW-1:0] L_LAST  = AW'(DEPTH - 1);

    logic [WL-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [WL-1:0] r_dout;
    logic          r_ov;
    logic          r_un;
    logic          r_err;

    logic          w_rd_ok;
    logic          w_wr_ok;
    logic          w_reject;

    // A write into a full FIFO is legal when a pop frees the slot in the same cycle.
    assign w_rd_ok  = rReq && (r_count != '0);
    assign w_wr_ok  = wReq && ((r_count != L_DEPTH) || w_rd_ok);
    assign w_reject = (wReq && !w_wr_ok) || (rReq && !w_rd_ok);

    always_ff @(posedge CLK) begin
        if (RST && !Flush && w_wr_ok) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_ov     <= 1'b0;
            r_un     <= 1'b0;
            r_err    <= 1'b0;
        end else if (Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ov     <= 1'b0;
            r_un     <= 1'b0;
            if (ErrClr) begin
                r_err <= 1'b0;
            end
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= (r_wr_ptr == L_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= (r_rd_ptr == L_LAST) ? '0 : r_rd_ptr + 1'b1;
                if (FWFT == 0) begin
                    r_dout <= r_mem[r_rd_ptr];
                end
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_ov <= wReq && !w_wr_ok;
            r_un <= rReq && !w_rd_ok;
            // A new event outranks a clear arriving on the same edge.
            if (w_reject) begin
                r_err <= 1'b1;
            end else if (ErrClr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign dout        = (FWFT != 0) ? r_mem[r_rd_ptr] : r_dout;
    assign Count       = r_count;
    assign Full        = (r_count == L_DEPTH);
    assign Empty       = (r_count == '0);
    assign AlmostFull  = (r_count >= L_AF);
    assign AlmostEmpty = (r_count <= L_AE);
    assign Overflow    = r_ov;
    assign Underflow   = r_un;
    assign Error       = r_err;
endmodule

// File: tb/tb_fifo_buffer_ext.sv
// tb/tb_fifo_buffer_ext.sv - three FIFO configurations on shared stimulus, checked against a queue model
module tb_fifo_buffer_ext;
    logic       clk = 1'b0;
    logic       rst_n, w_req, r_req, flush, err_clr;
    logic [7:0] din;

    logic [7:0] dout_w [3];
    logic       full_w [3];
    logic       empty_w [3];
    logic       af_w [3];
    logic       ae_w [3];
    logic       ov_w [3];
    logic       un_w [3];
    logic       err_w [3];
    logic [3:0] cnt_w [3];
    logic [3:0] cnt_a;
    logic [2:0] cnt_b, cnt_c;

    assign cnt_w[0] = cnt_a;
    assign cnt_w[1] = {1'b0, cnt_b};
    assign cnt_w[2] = {1'b0, cnt_c};

    int   P_D  [3] = '{8, 6, 4};
    int   P_AF [3] = '{6, 6, 1};
    int   P_AE [3] = '{2, 5, 0};
    bit   P_FW [3] = '{1'b0, 1'b0, 1'b1};

    logic [7:0] mq [3][$];
    logic [7:0] m_dout [3];
    logic       m_ov [3];
    logic       m_un [3];
    logic       m_err [3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    fifo_buffer_ext #(.WL(8), .DEPTH(8), .AF_LVL(6), .AE_LVL(2), .FWFT(0)) u_a (
        .CLK(clk), .RST(rst_n), .wReq(w_req), .rReq(r_req), .din(din), .Flush(flush), .ErrClr(err_clr),
        .dout(dout_w[0]), .Full(full_w[0]), .Empty(empty_w[0]), .AlmostFull(af_w[0]), .AlmostEmpty(ae_w[0]),
        .Count(cnt_a), .Overflow(ov_w[0]), .Underflow(un_w[0]), .Error(err_w[0]));
    fifo_buffer_ext #(.WL(8), .DEPTH(6), .AF_LVL(6), .AE_LVL(5), .FWFT(0)) u_b (
        .CLK(clk), .RST(rst_n), .wReq(w_req), .rReq(r_req), .din(din), .Flush(flush), .ErrClr(err_clr),
        .dout(dout_w[1]), .Full(full_w[1]), .Empty(empty_w[1]), .AlmostFull(af_w[1]), .AlmostEmpty(ae_w[1]),
        .Count(cnt_b), .Overflow(ov_w[1]), .Underflow(un_w[1]), .Error(err_w[1]));
    fifo_buffer_ext #(.WL(8), .DEPTH(4), .AF_LVL(1), .AE_LVL(0), .FWFT(1)) u_c (
        .CLK(clk), .RST(rst_n), .wReq(w_req), .rReq(r_req), .din(din), .Flush(flush), .ErrClr(err_clr),
        .dout(dout_w[2]), .Full(full_w[2]), .Empty(empty_w[2]), .AlmostFull(af_w[2]), .AlmostEmpty(ae_w[2]),
        .Count(cnt_c), .Overflow(ov_w[2]), .Underflow(un_w[2]), .Error(err_w[2]));

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            int         n;
            bit         rd_ok, wr_ok;
            logic [7:0] tmp;
            n = mq[i].size();
            if (!rst_n) begin
                mq[i].delete();
                m_dout[i] = 8'h00; m_ov[i] = 1'b0; m_un[i] = 1'b0; m_err[i] = 1'b0;
            end else if (flush) begin
                mq[i].delete();
                m_ov[i] = 1'b0; m_un[i] = 1'b0;
                if (err_clr) m_err[i] = 1'b0;
            end else begin
                rd_ok = r_req && (n > 0);
                wr_ok = w_req && ((n < P_D[i]) || rd_ok);
                if (rd_ok) begin
                    tmp = mq[i].pop_front();
                    if (!P_FW[i]) m_dout[i] = tmp;
                end
                if (wr_ok) mq[i].push_back(din);
                m_ov[i] = w_req && !wr_ok;
                m_un[i] = r_req && !rd_ok;
                if (m_ov[i] || m_un[i]) m_err[i] = 1'b1;
                else if (err_clr) m_err[i] = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic wi, input logic ri, input logic [7:0] di,
                         input logic fi, input logic ei, input logic rsti);
        w_req = wi; r_req = ri; din = di; flush = fi; err_clr = ei; rst_n = rsti;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (cnt_w[i] !== 4'd0) $display("FAIL reset_count[%0d]: got %0d exp 0", i, cnt_w[i]); else n_pass++;
            n_chk++; if ({empty_w[i], ae_w[i], full_w[i], af_w[i]} !== 4'b1100)
                $display("FAIL reset_flags[%0d]: got %b exp 1100", i, {empty_w[i], ae_w[i], full_w[i], af_w[i]}); else n_pass++;
            n_chk++; if ({ov_w[i], un_w[i], err_w[i]} !== 3'b000)
                $display("FAIL reset_err[%0d]: got %b exp 000", i, {ov_w[i], un_w[i], err_w[i]}); else n_pass++;
            if (!P_FW[i]) begin
                n_chk++; if (dout_w[i] !== 8'h00) $display("FAIL reset_dout[%0d]: got %h exp 00", i, dout_w[i]); else n_pass++;
            end
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] v [6] = '{8'd1, 8'd2, 8'd4, 8'd5, 8'd7, 8'd4};
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, 1'b0, v[k], 1'b0, 1'b0, 1'b1);
            n_chk++; if (cnt_w[0] !== 4'(k + 1)) $display("FAIL fill_count: got %0d exp %0d", cnt_w[0], k + 1); else n_pass++;
            n_chk++; if ({ae_w[0], af_w[0], full_w[0]} !== {1'(k + 1 <= 2), 1'(k + 1 >= 6), 1'b0})
                $display("FAIL fill_flags: got %b at count %0d", {ae_w[0], af_w[0], full_w[0]}, k + 1); else n_pass++;
        end
        for (int k = 0; k < 6; k++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
            n_chk++; if (dout_w[0] !== v[k]) $display("FAIL drain_dout: got %h exp %h", dout_w[0], v[k]); else n_pass++;
        end
        n_chk++; if (empty_w[0] !== 1'b1) $display("FAIL drain_empty: got %b exp 1", empty_w[0]); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 8'h30 + 8'(k), 1'b0, 1'b0, 1'b1);
        n_chk++; if (full_w[0] !== 1'b1) $display("FAIL ovf_full: got %b exp 1", full_w[0]); else n_pass++;
        cycle(1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b1);
        n_chk++; if ({ov_w[0], err_w[0], cnt_w[0]} !== {2'b11, 4'd8})
            $display("FAIL ovf_pulse: got ov=%b err=%b cnt=%0d exp 1 1 8", ov_w[0], err_w[0], cnt_w[0]); else n_pass++;
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_chk++; if ({ov_w[0], err_w[0]} !== 2'b01) $display("FAIL ovf_one_cycle: got ov=%b err=%b exp 0 1", ov_w[0], err_w[0]); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
            n_chk++; if (dout_w[0] !== 8'h30 + 8'(k)) $display("FAIL ovf_drain: got %h exp %h", dout_w[0], 8'h30 + 8'(k)); else n_pass++;
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        n_chk++; if (err_w[0] !== 1'b0) $display("FAIL errclr: got %b exp 0", err_w[0]); else n_pass++;
    endtask

    task automatic test_wrap();
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 8'(k), 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 8'd10 + 8'(k), 1'b0, 1'b0, 1'b1);
            n_chk++; if (cnt_w[1] !== 4'(k + 1)) $display("FAIL wrap_push_count: got %0d exp %0d", cnt_w[1], k + 1); else n_pass++;
        end
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
            n_chk++; if (dout_w[1] !== 8'd10 + 8'(k)) $display("FAIL wrap_dout: got %0d exp %0d", dout_w[1], 10 + k); else n_pass++;
            n_chk++; if (cnt_w[1] !== 4'(4 - k)) $display("FAIL wrap_pop_count: got %0d exp %0d", cnt_w[1], 4 - k); else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 8; k++) cycle(1'b1, 1'b0, 8'h50 + 8'(k), 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        n_chk++; if ({dout_w[0], cnt_w[0], ov_w[0]} !== {8'h50, 4'd8, 1'b0})
            $display("FAIL full_rw: got dout=%h cnt=%0d ov=%b exp 50 8 0", dout_w[0], cnt_w[0], ov_w[0]); else n_pass++;
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
            n_chk++; if (dout_w[0] !== ((k == 7) ? 8'hAA : 8'h51 + 8'(k)))
                $display("FAIL full_rw_drain: got %h at pop %0d", dout_w[0], k); else n_pass++;
        end
        cycle(1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        n_chk++; if ({un_w[0], cnt_w[0], dout_w[0]} !== {1'b1, 4'd1, 8'hAA})
            $display("FAIL empty_rw: got un=%b cnt=%0d dout=%h exp 1 1 aa", un_w[0], cnt_w[0], dout_w[0]); else n_pass++;
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        n_chk++; if (dout_w[0] !== 8'h33) $display("FAIL empty_rw_read: got %h exp 33", dout_w[0]); else n_pass++;
    endtask

    task automatic test_fwft();
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        n_chk++; if ({empty_w[2], dout_w[2]} !== {1'b0, 8'h11}) $display("FAIL fwft_first: got %h exp 11", dout_w[2]); else n_pass++;
        cycle(1'b1, 1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        n_chk++; if (dout_w[2] !== 8'h11) $display("FAIL fwft_hold: got %h exp 11", dout_w[2]); else n_pass++;
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        n_chk++; if (dout_w[2] !== 8'h22) $display("FAIL fwft_pop: got %h exp 22", dout_w[2]); else n_pass++;
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        n_chk++; if (empty_w[2] !== 1'b1) $display("FAIL fwft_empty: got %b exp 1", empty_w[2]); else n_pass++;
    endtask

    task automatic test_flush_reset();
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, 8'hC0 + 8'(k), 1'b0, 1'b0, 1'b1);
        n_chk++; if ({cnt_w[0], err_w[0]} !== {4'd5, 1'b1}) $display("FAIL pre_flush: got cnt=%0d err=%b exp 5 1", cnt_w[0], err_w[0]); else n_pass++;
        cycle(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
        n_chk++; if ({cnt_w[0], empty_w[0], err_w[0], ov_w[0], un_w[0]} !== {4'd0, 4'b1100})
            $display("FAIL flush: got cnt=%0d empty=%b err=%b ov=%b un=%b", cnt_w[0], empty_w[0], err_w[0], ov_w[0], un_w[0]); else n_pass++;
        cycle(1'b1, 1'b0, 8'hD0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 8'hD1, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 8'hD2, 1'b0, 1'b0, 1'b0);
        n_chk++; if ({cnt_w[0], empty_w[0], ae_w[0], full_w[0], af_w[0], err_w[0], dout_w[0]} !== {4'd0, 5'b11000, 8'h00})
            $display("FAIL mid_reset: got cnt=%0d err=%b dout=%h", cnt_w[0], err_w[0], dout_w[0]); else n_pass++;
        cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        n_chk++; if (dout_w[0] !== 8'h77) $display("FAIL post_reset_read: got %h exp 77", dout_w[0]); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            logic fi;
            int   wp;
            wp = ((c / 300) % 2 == 0) ? 75 : 30;
            fi = ($urandom_range(99) < 2);
            cycle($urandom_range(99) < wp, $urandom_range(99) < 50, 8'($urandom),
                  fi, !fi && ($urandom_range(99) < 4), $urandom_range(499) != 0);
            for (int i = 0; i < 3; i++) begin
                int n;
                n = mq[i].size();
                n_chk++; if (cnt_w[i] !== 4'(n)) $display("FAIL rnd_count[%0d] cyc %0d: got %0d exp %0d", i, c, cnt_w[i], n); else n_pass++;
                n_chk++; if ({full_w[i], empty_w[i], af_w[i], ae_w[i]} !== {1'(n == P_D[i]), 1'(n == 0), 1'(n >= P_AF[i]), 1'(n <= P_AE[i])})
                    $display("FAIL rnd_flags[%0d] cyc %0d: got %b at count %0d", i, c, {full_w[i], empty_w[i], af_w[i], ae_w[i]}, n); else n_pass++;
                n_chk++; if ({ov_w[i], un_w[i], err_w[i]} !== {m_ov[i], m_un[i], m_err[i]})
                    $display("FAIL rnd_err[%0d] cyc %0d: got %b exp %b", i, c, {ov_w[i], un_w[i], err_w[i]}, {m_ov[i], m_un[i], m_err[i]}); else n_pass++;
                if (!P_FW[i]) begin
                    n_chk++; if (dout_w[i] !== m_dout[i]) $display("FAIL rnd_dout[%0d] cyc %0d: got %h exp %h", i, c, dout_w[i], m_dout[i]); else n_pass++;
                end else if (n > 0) begin
                    n_chk++; if (dout_w[i] !== mq[i][0]) $display("FAIL rnd_fwft[%0d] cyc %0d: got %h exp %h", i, c, dout_w[i], mq[i][0]); else n_pass++;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; w_req = 1'b0; r_req = 1'b0; din = 8'h00; flush = 1'b0; err_clr = 1'b0;
        test_reset();
        test_fill_drain();
        test_overflow();
        test_wrap();
        test_simultaneous();
        test_fwft();
        test_flush_reset();
        test_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
